// File: rtl/key_scan_pkg.sv
// Shared types and constants for the matrix key scanner.
// Repeat timing constants are used only when KEY_AUTOREPEAT_EN is defined.
package key_scan_pkg;

  localparam logic [1:0] ST_DRIVE  = 2'd0;
  localparam logic [1:0] ST_SAMPLE = 2'd1;
  localparam logic [1:0] ST_EMIT   = 2'd2;

  localparam int CODE_W_MAX = 6;

  localparam int RPT_FIRST = 64;
  localparam int RPT_NEXT  = 16;
  localparam int RPT_W     = 7;

  typedef struct packed {
    logic [CODE_W_MAX-1:0] code;
    logic                  press;
  } key_evt_t;

endpackage

// File: rtl/key_evt_fifo.sv
// Event queue: power-of-two depth, valid/ready pop side,
// push with full flag; push and pop may share a clock when full.
module key_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 7
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign pop_valid = cnt_q != '0;
  assign full      = cnt_q == FULL_C;
  assign do_pop    = pop_valid & pop_ready;
  assign do_push   = push & (~full | do_pop);
  assign pop_data  = pop_valid ? mem[rd_q] : '0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_q] <= push_data;
  end

endmodule

// File: rtl/matrix_key_scanner.sv
// Column-scanned key matrix with per-key debounce, ghost filter and event FIFO.
// Optional auto-repeat of a single held key: define KEY_AUTOREPEAT_EN.
module matrix_key_scanner
  import key_scan_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 65536,
  parameter int DEB_SCANS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic [ROWS-1:0]               Row_i,
  output logic [COLS-1:0]               Col_o,
  output logic                          Evt_Valid,
  input  logic                          Evt_Ready,
  output logic [$clog2(ROWS*COLS)-1:0]  Evt_Code,
  output logic                          Evt_Press,
  output logic                          Overflow,
  input  logic                          Ovf_Clr
);

  localparam int KW = $clog2(ROWS*COLS);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [3:0] DEB_M1 = 4'(DEB_SCANS-1);

  logic [DW-1:0]   div_q;
  logic            tick;
  logic [1:0]      st_q, st_d;
  logic [CW-1:0]   c_q, c_d;
  logic [RW-1:0]   r_q, r_d;
  logic [ROWS-1:0] row_s1, row_s2, samp_q;
  logic [COLS-1:0] col_q, col_sel;
  logic [COLS-1:0] deb_q [ROWS];
  logic [3:0]      cnt_q [ROWS][COLS];
  logic [3:0]      cnt_cur, cnt_nxt;
  logic            emit, raw, diff, reach;
  logic            ghost, toggle, hold;
  logic            rpt_push, evt_push;
  logic            fifo_full, ovf_q, drop;
  key_evt_t        key_evt, rpt_evt;
  key_evt_t        push_evt, head;

  assign tick = div_q == DW'(SCAN_DIV-1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) div_q <= '0;
    else        div_q <= tick ? '0 : div_q + 1'b1;
  end

  always_comb begin
    st_d = st_q;
    c_d  = c_q;
    r_d  = r_q;
    unique case (1'b1)
      st_q == ST_DRIVE: begin
        if (tick) st_d = ST_SAMPLE;
      end
      st_q == ST_SAMPLE: begin
        if (tick) begin
          st_d = ST_EMIT;
          r_d  = '0;
        end
      end
      st_q == ST_EMIT: begin
        if (r_q == RW'(ROWS-1)) begin
          st_d = ST_DRIVE;
          r_d  = '0;
          c_d  = (c_q == CW'(COLS-1)) ? '0 : c_q + 1'b1;
        end else begin
          r_d = r_q + 1'b1;
        end
      end
      default: st_d = ST_DRIVE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      st_q   <= ST_DRIVE;
      c_q    <= '0;
      r_q    <= '0;
      col_q  <= '1;
      row_s1 <= '1;
      row_s2 <= '1;
      samp_q <= '1;
    end else begin
      st_q   <= st_d;
      c_q    <= c_d;
      r_q    <= r_d;
      col_q  <= ~(COLS'(1) << c_d);
      row_s1 <= Row_i;
      row_s2 <= row_s1;
      if (st_q == ST_SAMPLE && tick) samp_q <= row_s2;
    end
  end

  assign Col_o   = col_q;
  assign col_sel = COLS'(1) << c_q;

  assign emit    = st_q == ST_EMIT;
  assign raw     = ~samp_q[r_q];
  assign cnt_cur = cnt_q[r_q][c_q];
  assign diff    = raw != deb_q[r_q][c_q];
  assign reach   = cnt_cur == DEB_M1;

  // A new press is a ghost if another row shares this column and
  // also shares a second pressed column with this key's row.
  always_comb begin
    ghost = 1'b0;
    for (int r2 = 0; r2 < ROWS; r2++) begin
      if (RW'(r2) != r_q && deb_q[RW'(r2)][c_q] &&
          |(deb_q[RW'(r2)] & deb_q[r_q] & ~col_sel))
        ghost = 1'b1;
    end
  end

  assign toggle = emit & diff & reach & ~(raw & ghost);
  assign hold   = emit & diff & reach & raw & ghost;

  always_comb begin
    cnt_nxt = '0;
    if (diff) begin
      if (toggle)    cnt_nxt = '0;
      else if (hold) cnt_nxt = DEB_M1;
      else           cnt_nxt = cnt_cur + 4'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        deb_q[r] <= '0;
        for (int c = 0; c < COLS; c++) cnt_q[r][c] <= '0;
      end
    end else if (emit) begin
      cnt_q[r_q][c_q] <= cnt_nxt;
      if (toggle) deb_q[r_q][c_q] <= raw;
    end
  end

  assign key_evt.code  = CODE_W_MAX'(r_q) * CODE_W_MAX'(COLS)
                       + CODE_W_MAX'(c_q);
  assign key_evt.press = raw;

`ifdef KEY_AUTOREPEAT_EN
  logic [RPT_W-1:0]      rpt_q;
  logic [RPT_W-1:0]      n_down;
  logic [CODE_W_MAX-1:0] held_code;
  logic                  chg_q, due_q, scan_end;

  always_comb begin
    n_down    = '0;
    held_code = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (deb_q[RW'(r)][CW'(c)]) begin
          n_down    = n_down + 1'b1;
          held_code = CODE_W_MAX'(r*COLS + c);
        end
      end
    end
  end

  assign scan_end = emit && r_q == RW'(ROWS-1) && c_q == CW'(COLS-1);

  // Repeats are pushed in DRIVE, where no key event can compete.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rpt_q <= '0;
      chg_q <= 1'b0;
      due_q <= 1'b0;
    end else begin
      if (toggle) chg_q <= 1'b1;
      if (rpt_push) due_q <= 1'b0;
      if (scan_end) begin
        chg_q <= 1'b0;
        if (chg_q || toggle || n_down != RPT_W'(1)) begin
          rpt_q <= '0;
        end else if (rpt_q == RPT_W'(RPT_FIRST-1)) begin
          rpt_q <= RPT_W'(RPT_FIRST-RPT_NEXT);
          due_q <= 1'b1;
        end else begin
          rpt_q <= rpt_q + 1'b1;
        end
      end
    end
  end

  assign rpt_push      = due_q & (st_q == ST_DRIVE) & (n_down == RPT_W'(1));
  assign rpt_evt.code  = held_code;
  assign rpt_evt.press = 1'b1;
`else
  assign rpt_push = 1'b0;
  assign rpt_evt  = '0;
`endif

  assign evt_push = toggle | rpt_push;
  assign push_evt = rpt_push ? rpt_evt : key_evt;

  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(key_evt_t))
  ) u_fifo (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .push      (evt_push),
    .push_data (push_evt),
    .full      (fifo_full),
    .pop_valid (Evt_Valid),
    .pop_ready (Evt_Ready),
    .pop_data  (head)
  );

  assign Evt_Code  = head.code[KW-1:0];
  assign Evt_Press = head.press;

  generate
    if (KW < CODE_W_MAX) begin : g_code_pad
      logic unused_hi;
      assign unused_hi = |head.code[CODE_W_MAX-1:KW];
    end
  endgenerate

  assign drop = evt_push & fifo_full & ~(Evt_Valid & Evt_Ready);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)       ovf_q <= 1'b0;
    else if (drop)    ovf_q <= 1'b1;
    else if (Ovf_Clr) ovf_q <= 1'b0;
  end

  assign Overflow = ovf_q;

endmodule
